// File: rtl/rand_queue.sv
// Single-clock circular-buffer queue with runtime FIFO / random-pop order.
// In random mode an LFSR picks the popped entry, and the head entry moves into the slot it vacates.
module rand_queue #(
   parameter int          WIDTH        = 8,
   parameter int          DEPTH        = 16,
   parameter int          AFULL_THRESH = DEPTH - 2,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       wr_en_i,
   input  logic                       rd_en_i,
   input  logic                       rand_en_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 16 + AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, k;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             push_ok, pop_ok;
   logic [PW-1:0]    prod;

   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == (AW+1)'(DEPTH));
   assign almost_full_o = (count_q >= (AW+1)'(AFULL_THRESH));
   assign count_o       = count_q;
   assign dout_o        = dout_q;
   assign overflow_o    = ovf_q;
   assign underflow_o   = unf_q;

   assign push_ok = wr_en_i & ~full_o;
   assign pop_ok  = rd_en_i & ~empty_o;

   // off = (lfsr * count) >> 16 is always < count, so it lands inside the occupied region
   assign prod = PW'(lfsr_q) * PW'(count_q);
   assign k    = rand_en_i ? AW'((prod >> 16) + PW'(rd_ptr_q)) : rd_ptr_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      lfsr_d   = lfsr_q;
      ovf_d    = wr_en_i & full_o;
      unf_d    = rd_en_i & empty_o;
      if (pop_ok) begin
         dout_d   = mem[k];
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (rand_en_i)
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
      if (push_ok)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_ok && !pop_ok)
         count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         lfsr_q   <= LFSR_SEED;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         lfsr_q   <= lfsr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Push slot (wr_ptr) is outside the occupied region whenever a push is accepted,
   // so it never coincides with the move target k.
   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         if (pop_ok)
            mem[k] <= mem[rd_ptr_q];
         if (push_ok)
            mem[wr_ptr_q] <= din_i;
      end
   end
endmodule
